// File: rtl/sm_dmem_io.sv
// Data-memory responder for the single-cycle CPU: local word RAM plus a small
// memory-mapped I/O block (GPIO, cycle counter, compare timer with interrupt).
module sm_dmem_io #(
    parameter int AW     = 6,
    parameter int GPIO_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dmAddr,
    input  logic              dmWe,
    input  logic [31:0]       dmWData,
    output logic [31:0]       dmRData,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
    localparam logic [2:0] OFF_CYCLE    = 3'd2;
    localparam logic [2:0] OFF_TCMP     = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_TCNT     = 3'd5;

    logic [31:0]       mem_r [2**AW];
    logic [GPIO_W-1:0] gpio_out_r;
    logic [GPIO_W-1:0] sync1_r;
    logic [GPIO_W-1:0] sync2_r;
    logic [31:0]       cycle_r;
    logic [31:0]       tcmp_r;
    logic [2:0]        ctrl_r;
    logic [30:0]       tcnt_r;
    logic              tstat_r;
    logic              irq_r;

    logic              io_sel_s;
    logic [2:0]        off_s;
    logic [AW-1:0]     ram_idx_s;
    logic              we_ram_s;
    logic              we_gpio_s;
    logic              we_cycle_s;
    logic              we_tcmp_s;
    logic              we_ctrl_s;
    logic              we_tcnt_s;
    logic              match_s;
    logic [31:0]       rdata_s;
    logic              unused_s;

    function automatic logic [31:0] zext_gpio(input logic [GPIO_W-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[GPIO_W-1:0] = v;
        return r;
    endfunction

    // Address decode and per-register write strobes
    always_comb begin
        io_sel_s   = (dmAddr[31:28] == 4'hF);
        off_s      = dmAddr[4:2];
        ram_idx_s  = dmAddr[AW+1:2];
        we_ram_s   = dmWe & ~io_sel_s;
        we_gpio_s  = 1'b0;
        we_cycle_s = 1'b0;
        we_tcmp_s  = 1'b0;
        we_ctrl_s  = 1'b0;
        we_tcnt_s  = 1'b0;
        if (dmWe && io_sel_s) begin
            case (off_s)
                OFF_GPIO_OUT: we_gpio_s  = 1'b1;
                OFF_CYCLE:    we_cycle_s = 1'b1;
                OFF_TCMP:     we_tcmp_s  = 1'b1;
                OFF_CTRL:     we_ctrl_s  = 1'b1;
                OFF_TCNT:     we_tcnt_s  = 1'b1;
                default:      we_gpio_s  = 1'b0;
            endcase
        end else begin
            we_gpio_s = 1'b0;
        end
    end

    assign match_s = ctrl_r[0] && (tcnt_r == tcmp_r[30:0]);

    // Combinational read mux; RAM read returns pre-write data on same-cycle writes
    always_comb begin
        rdata_s = 32'd0;
        if (io_sel_s) begin
            case (off_s)
                OFF_GPIO_OUT: rdata_s = zext_gpio(gpio_out_r);
                OFF_GPIO_IN:  rdata_s = zext_gpio(sync2_r);
                OFF_CYCLE:    rdata_s = cycle_r;
                OFF_TCMP:     rdata_s = tcmp_r;
                OFF_CTRL:     rdata_s = {29'd0, ctrl_r};
                OFF_TCNT:     rdata_s = {tstat_r, tcnt_r};
                default:      rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = mem_r[ram_idx_s];
        end
    end

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we_ram_s && !rst) begin
            mem_r[ram_idx_s] <= dmWData;
        end
    end

    // I/O registers, timer and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out_r <= '0;
            sync1_r    <= '0;
            sync2_r    <= '0;
            cycle_r    <= 32'd0;
            tcmp_r     <= 32'd0;
            ctrl_r     <= 3'd0;
            tcnt_r     <= 31'd0;
            tstat_r    <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            sync1_r <= gpio_in;
            sync2_r <= sync1_r;
            irq_r   <= tstat_r & ctrl_r[2];

            if (we_gpio_s) begin
                gpio_out_r <= dmWData[GPIO_W-1:0];
            end
            if (we_tcmp_s) begin
                tcmp_r <= dmWData;
            end

            if (we_cycle_s) begin
                cycle_r <= dmWData;
            end else begin
                cycle_r <= cycle_r + 32'd1;
            end

            // A CPU write to CTRL overrides the one-shot auto-disable
            if (we_ctrl_s) begin
                ctrl_r <= dmWData[2:0];
            end else if (match_s && !we_tcnt_s && !ctrl_r[1]) begin
                ctrl_r[0] <= 1'b0;
            end

            // A TCNT write suppresses the timer step; a pending match still blocks the clear
            if (we_tcnt_s) begin
                tcnt_r <= dmWData[30:0];
                if (dmWData[31] && !match_s) begin
                    tstat_r <= 1'b0;
                end
            end else if (match_s) begin
                tcnt_r  <= 31'd0;
                tstat_r <= 1'b1;
            end else if (ctrl_r[0]) begin
                tcnt_r <= tcnt_r + 31'd1;
            end
        end
    end

    assign dmRData  = rdata_s;
    assign gpio_out = gpio_out_r;
    assign irq      = irq_r;
    assign unused_s = ^{dmAddr, tcmp_r[31]};

endmodule

// File: tb/tb_sm_dmem_io.sv
// Directed self-checking bench for sm_dmem_io: RAM, GPIO, cycle counter,
// autoreload and one-shot timer, and reset behaviour.
module tb_sm_dmem_io;

    localparam logic [31:0] A_GPO  = 32'hF000_0000;
    localparam logic [31:0] A_GPI  = 32'hF000_0004;
    localparam logic [31:0] A_CYC  = 32'hF000_0008;
    localparam logic [31:0] A_TCMP = 32'hF000_000C;
    localparam logic [31:0] A_CTRL = 32'hF000_0010;
    localparam logic [31:0] A_TCNT = 32'hF000_0014;
    localparam logic [31:0] A_OFF6 = 32'hF000_0018;
    localparam logic [31:0] A_OFF7 = 32'hF000_001C;

    logic        clk;
    logic        rst;
    logic [31:0] dmAddr;
    logic        dmWe;
    logic [31:0] dmWData;
    logic [31:0] dmRData;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        irq;

    int n_total;
    int n_pass;
    int n_fail;

    sm_dmem_io #(.AW(6), .GPIO_W(16)) dut (
        .clk(clk), .rst(rst), .dmAddr(dmAddr), .dmWe(dmWe), .dmWData(dmWData),
        .dmRData(dmRData), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dmAddr  = a;
        dmWData = d;
        dmWe    = 1'b1;
        tick();
        dmWe    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        dmAddr = a;
        #1;
        chk(tag, dmRData, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst     = 1'b1;
        dmAddr  = 32'd0;
        dmWe    = 1'b0;
        dmWData = 32'd0;
        gpio_in = 16'd0;
        tick();
        tick();
        rst = 1'b0;

        // reset state and cycle counter start
        chk("rst_gpio_out", {16'd0, gpio_out}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd("rst_cycle0", A_CYC, 32'd0);
        rd("rst_ctrl", A_CTRL, 32'd0);
        tick();
        rd("rst_cycle1", A_CYC, 32'd1);

        // RAM, aliasing, read-during-write
        wr(32'h10, 32'hDEAD_BEEF);
        wr(32'h14, 32'hCAFE_F00D);
        rd("ram_10", 32'h10, 32'hDEAD_BEEF);
        rd("ram_14", 32'h14, 32'hCAFE_F00D);
        rd("ram_alias", 32'h110, 32'hDEAD_BEEF);
        wr(32'h18, 32'hA0A0_A0A0);
        dmAddr  = 32'h18;
        dmWData = 32'h5555_5555;
        dmWe    = 1'b1;
        #1;
        chk("ram_rdw_old", dmRData, 32'hA0A0_A0A0);
        tick();
        dmWe = 1'b0;
        rd("ram_rdw_new", 32'h18, 32'h5555_5555);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd("ram_keep_rst", 32'h10, 32'hDEAD_BEEF);

        // GPIO out and synchronized input
        wr(A_GPO, 32'h1234_A5A5);
        chk("gpio_out", {16'd0, gpio_out}, 32'h0000_A5A5);
        rd("gpo_read", A_GPO, 32'h0000_A5A5);
        gpio_in = 16'h00FF;
        rd("gpi_c1", A_GPI, 32'd0);
        tick();
        rd("gpi_c2", A_GPI, 32'd0);
        tick();
        rd("gpi_c3", A_GPI, 32'h0000_00FF);

        // cycle counter wrap and unmapped offsets
        wr(A_CYC, 32'hFFFF_FFFE);
        rd("cyc_0", A_CYC, 32'hFFFF_FFFE);
        tick();
        rd("cyc_1", A_CYC, 32'hFFFF_FFFF);
        tick();
        rd("cyc_wrap", A_CYC, 32'h0);
        wr(A_OFF7, 32'hFFFF_FFFF);
        rd("off7", A_OFF7, 32'd0);
        rd("off6", A_OFF6, 32'd0);
        rd("off7_gpo", A_GPO, 32'h0000_A5A5);
        rd("off7_tcmp", A_TCMP, 32'd0);
        rd("off7_ctrl", A_CTRL, 32'd0);

        // autoreload timer, period 5
        wr(A_TCMP, 32'd4);
        wr(A_CTRL, 32'd7);
        rd("ar_t0", A_TCNT, 32'd0);
        tick(); tick(); tick(); tick();
        rd("ar_t4", A_TCNT, 32'd4);
        chk("ar_irq_pre", {31'd0, irq}, 32'd0);
        tick();
        rd("ar_match", A_TCNT, 32'h8000_0000);
        chk("ar_irq_lag", {31'd0, irq}, 32'd0);
        tick();
        rd("ar_after", A_TCNT, 32'h8000_0001);
        chk("ar_irq", {31'd0, irq}, 32'd1);
        tick(); tick(); tick();
        rd("ar_t4b", A_TCNT, 32'h8000_0004);
        wr(A_TCNT, 32'h8000_0002);
        rd("ar_wr_wins", A_TCNT, 32'h8000_0002);
        wr(A_TCNT, 32'h8000_0000);
        rd("ar_clear", A_TCNT, 32'h0);
        chk("ar_irq_hold", {31'd0, irq}, 32'd1);
        tick();
        rd("ar_clr_t1", A_TCNT, 32'h1);
        chk("ar_irq_drop", {31'd0, irq}, 32'd0);
        tick(); tick(); tick();
        rd("ar_t4c", A_TCNT, 32'h4);
        tick();
        rd("ar_match2", A_TCNT, 32'h8000_0000);
        tick();
        chk("ar_irq2", {31'd0, irq}, 32'd1);
        wr(A_CTRL, 32'd0);
        wr(A_TCNT, 32'h8000_0000);

        // one-shot timer
        wr(A_TCMP, 32'd2);
        wr(A_CTRL, 32'd5);
        rd("os_ctrl", A_CTRL, 32'd5);
        tick(); tick();
        rd("os_t2", A_TCNT, 32'd2);
        tick();
        rd("os_match", A_TCNT, 32'h8000_0000);
        rd("os_ctrl_clr", A_CTRL, 32'd4);
        tick();
        chk("os_irq", {31'd0, irq}, 32'd1);
        tick();
        rd("os_stay", A_TCNT, 32'h8000_0000);
        chk("os_irq_hold", {31'd0, irq}, 32'd1);
        wr(A_TCNT, 32'h8000_0000);
        rd("os_clr", A_TCNT, 32'd0);
        tick();
        chk("os_irq_off", {31'd0, irq}, 32'd0);

        // CTRL write beats one-shot auto-disable
        wr(A_CTRL, 32'd5);
        tick(); tick();
        rd("cw_t2", A_TCNT, 32'd2);
        wr(A_CTRL, 32'd5);
        rd("cw_ctrl", A_CTRL, 32'd5);
        rd("cw_tcnt", A_TCNT, 32'h8000_0000);
        wr(A_CTRL, 32'd0);
        wr(A_TCMP, 32'd10);
        wr(A_TCNT, 32'h8000_0000);

        // reset mid-count with a same-cycle GPIO write
        wr(A_CTRL, 32'd7);
        tick(); tick(); tick();
        rd("mid_t3", A_TCNT, 32'd3);
        rst     = 1'b1;
        dmAddr  = A_GPO;
        dmWData = 32'h0000_FFFF;
        dmWe    = 1'b1;
        tick();
        rst  = 1'b0;
        dmWe = 1'b0;
        chk("mid_gpio_out", {16'd0, gpio_out}, 32'd0);
        chk("mid_irq", {31'd0, irq}, 32'd0);
        rd("mid_gpo", A_GPO, 32'd0);
        rd("mid_gpi", A_GPI, 32'd0);
        rd("mid_cyc", A_CYC, 32'd0);
        rd("mid_tcmp", A_TCMP, 32'd0);
        rd("mid_ctrl", A_CTRL, 32'd0);
        rd("mid_tcnt", A_TCNT, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
